pixel_streamer: RTL
===================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 10, pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 10, rows per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, memory address bits.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 10, Valid-low cycles after the last pixel; must be >= 1.
REQ-006 SHALL have port clk, input, 1, sole clock; rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port Start, input, 1, frame start request, sampled in IDLE only.
REQ-009 SHALL have port Pause, input, 1, suppresses issue of the next sample while high.
REQ-010 SHALL have port Mem_Rd_En, output, 1, frame-memory read strobe.
REQ-011 SHALL have port Mem_Addr, output, ADDR_WIDTH, read address = row*IMG_WIDTH + col.
REQ-012 SHALL have port Mem_Data, input, DATA_WIDTH, read data, valid exactly one cycle after Mem_Rd_En.
REQ-013 SHALL have port Valid_Out, output, 1, pixel strobe to the downstream line-buffer chain.
REQ-014 SHALL have port Data_Out, output, DATA_WIDTH, pixel value.
REQ-015 SHALL have ports Busy and Done, outputs, 1 each: Busy high outside IDLE; Done is a one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE -> READ on the edge where Start=1; Start is ignored in all other states.
REQ-018 In READ, each cycle with Pause=0 SHALL assert Mem_Rd_En for the current (row,col) and advance col; col wraps IMG_WIDTH-1 -> 0 with row+1.
REQ-019 In READ with Pause=1, Mem_Rd_En SHALL be 0 and row/col SHALL hold.
REQ-020 Valid_Out SHALL equal Mem_Rd_En delayed by exactly one cycle, with Data_Out = Mem_Data registered in that same cycle; fixed latency 1.
REQ-021 When Data_Out is not valid, Data_Out SHALL be 0.
REQ-022 After the read of (IMG_HEIGHT-1, IMG_WIDTH-1) is issued, READ -> DRAIN; the first DRAIN cycle carries the final Valid_Out=1 pixel.
REQ-023 DRAIN SHALL last DRAIN_CYCLES cycles, counted from the first cycle with Valid_Out=0; Pause has no effect in DRAIN.
REQ-024 DRAIN -> DONE; DONE asserts Done for one cycle, then -> IDLE.
REQ-025 Exactly IMG_WIDTH*IMG_HEIGHT Valid_Out pulses SHALL occur per frame, in raster order.
REQ-026 A Start pulse in the DONE cycle SHALL be ignored; back-to-back frames require a Start in IDLE.
REQ-027 Address arithmetic SHALL use an incrementing address register, not a multiplier; overflow beyond ADDR_WIDTH is a parameter error, not handled.

Reset
REQ-028 rst=0 SHALL force IDLE and clear row, col, and the drain counter immediately, regardless of clock.
REQ-029 Reset values SHALL be: Mem_Rd_En=0, Mem_Addr=0, Valid_Out=0, Data_Out=0, Busy=0, Done=0.
REQ-030 Reset mid-frame SHALL abandon the frame; no further Valid_Out until a new Start.

Configuration
REQ-031 With PIXEL_STREAMER_ZERO_PAD_EN defined, the streamer SHALL emit a one-pixel zero border: (IMG_WIDTH+2)*(IMG_HEIGHT+2) samples in raster order.
REQ-032 With the macro defined, border samples SHALL have Valid_Out=1 and Data_Out=0 with no memory read, keep the same one-cycle latency, and respect Pause.
REQ-033 Without the macro, no border logic SHALL exist and REQ-025 applies unchanged.

Structure
REQ-034 Package pixel_streamer_pkg SHALL hold the state enum and a clog2-based width constant function.
REQ-035 Sub-module pixel_pos_counter SHALL hold the row/col counters with wrap, enable, and last-pixel flag.

Verification
REQ-036 W=4,H=3, Start pulse, Pause=0 -> addresses 0..11 on consecutive cycles; 12 Valid_Out pulses echoing Mem_Data; Done at cycle 1+12+10+1 after Start.
REQ-037 Pause high for 3 cycles after address 5 -> Mem_Rd_En low 3 cycles, address 6 resumes, no pixel lost or duplicated.
REQ-038 Start asserted during READ and during DONE -> ignored; exactly one frame emitted.
REQ-039 rst low at address 7 -> all outputs 0 within the same cycle; next Start restarts at address 0.
REQ-040 PIXEL_STREAMER_ZERO_PAD_EN, W=2,H=2 -> 16 samples; only samples 5,6,9,10 nonzero and sourced from addresses 0..3.
REQ-041 DRAIN_CYCLES=1 -> exactly one Valid-low cycle between the last pixel and Done.

Source files
------------

// File: rtl/pixel_streamer_pkg.sv
// Shared types and helpers for the pixel streamer: FSM state encoding and
// counter width sizing.
package pixel_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster row/col counter: col wraps W_CNT-1 -> 0 carrying into row; flags the
// last position of the frame.
module pixel_pos_counter #(
  parameter int W_CNT = 10,
  parameter int H_CNT = 10,
  parameter int CW    = 4,
  parameter int RW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W_CNT - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H_CNT - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/pixel_streamer.sv
// Frame-memory to pixel-stream reader with fixed one-cycle read latency.
// Define PIXEL_STREAMER_ZERO_PAD_EN to wrap the frame in a one-pixel zero border.
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int IMG_WIDTH    = 10,
  parameter int IMG_HEIGHT   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Pause,
  output logic                  Mem_Rd_En,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DATA_WIDTH-1:0] Mem_Data,
  output logic                  Valid_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Busy,
  output logic                  Done
);

`ifdef PIXEL_STREAMER_ZERO_PAD_EN
  localparam int W_CNT = IMG_WIDTH + 2;
  localparam int H_CNT = IMG_HEIGHT + 2;
`else
  localparam int W_CNT = IMG_WIDTH;
  localparam int H_CNT = IMG_HEIGHT;
`endif
  localparam int CW  = cnt_w(W_CNT);
  localparam int RW  = cnt_w(H_CNT);
  localparam int DCW = cnt_w(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRN_MAX = DCW'(DRAIN_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DCW-1:0]        drn_q, drn_d;
  logic                  valid_q;
  logic                  issue;
  logic                  last;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;

  // One sample slot per unpaused READ cycle, whether memory or border.
  assign issue = (state_q == ST_READ) && !Pause;

  pixel_pos_counter #(
    .W_CNT (W_CNT),
    .H_CNT (H_CNT),
    .CW    (CW),
    .RW    (RW)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst),
    .clr   (state_q == ST_IDLE),
    .en    (issue),
    .row   (row),
    .col   (col),
    .last  (last)
  );

`ifdef PIXEL_STREAMER_ZERO_PAD_EN
  logic interior;
  logic border_q;

  assign interior  = (row >= RW'(1)) && (row <= RW'(IMG_HEIGHT)) &&
                     (col >= CW'(1)) && (col <= CW'(IMG_WIDTH));
  assign Mem_Rd_En = issue && interior;
  assign Data_Out  = (valid_q && !border_q) ? Mem_Data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) border_q <= 1'b0;
    else      border_q <= issue && !interior;
  end
`else
  logic unused_pos;
  assign unused_pos = ^{row, col};
  assign Mem_Rd_En  = issue;
  assign Data_Out   = valid_q ? Mem_Data : '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drn_d   = '0;
    // Interior pixels come out in address order, so a bare incrementer suffices.
    if (Mem_Rd_En) addr_d = addr_q + ADDR_WIDTH'(1);
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (Start) state_d = ST_READ;
      end
      ST_READ: if (issue && last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        drn_d = drn_q;
        // The first DRAIN cycle still carries the final pixel and is not counted.
        if (!valid_q) begin
          if (drn_q == DRN_MAX) state_d = ST_DONE;
          else                  drn_d   = drn_q + DCW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drn_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      valid_q <= issue;
    end
  end

  assign Mem_Addr  = addr_q;
  assign Valid_Out = valid_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);

endmodule
